// File: rtl/tone_decoder_pkg.sv
// Shared note codes, nominal periods at 100 MHz and classifier helpers
// for the tone decoder and the square-wave tone generator.
package tone_decoder_pkg;

    typedef enum logic [3:0] {
        NOTE_NONE = 4'd0,
        NOTE_C4   = 4'd1,
        NOTE_D    = 4'd2,
        NOTE_E    = 4'd3,
        NOTE_F    = 4'd4,
        NOTE_G    = 4'd5,
        NOTE_A    = 4'd6,
        NOTE_B    = 4'd7,
        NOTE_C5   = 4'd8
    } note_t;

    typedef enum logic [1:0] {
        ST_SILENT,
        ST_ACQUIRE,
        ST_LOCKED
    } state_t;

    localparam int unsigned P_C4 = 382219;
    localparam int unsigned P_D  = 340530;
    localparam int unsigned P_E  = 303372;
    localparam int unsigned P_F  = 286344;
    localparam int unsigned P_G  = 255102;
    localparam int unsigned P_A  = 227273;
    localparam int unsigned P_B  = 202478;
    localparam int unsigned P_C5 = 191113;

    localparam int NUM_NOTES = 8;

    function automatic logic [31:0] nominal_period(input int k);
        logic [31:0] p;
        case (k)
            1:       p = P_C4;
            2:       p = P_D;
            3:       p = P_E;
            4:       p = P_F;
            5:       p = P_G;
            6:       p = P_A;
            7:       p = P_B;
            8:       p = P_C5;
            default: p = '0;
        endcase
        return p;
    endfunction

    // NOTE_NONE doubles as "no window matched"
    function automatic note_t classify(
        input logic [31:0] period,
        input int          note_shift,
        input int          tol_shift
    );
        note_t       res;
        logic [31:0] nom;
        logic [31:0] tol;
        logic [31:0] diff;
        res = NOTE_NONE;
        for (int k = 1; k <= NUM_NOTES; k++) begin
            nom  = nominal_period(k) >> note_shift;
            tol  = nom >> tol_shift;
            diff = (period >= nom) ? (period - nom) : (nom - period);
            if (diff <= tol)
                res = note_t'(4'(k));
        end
        return res;
    endfunction

    function automatic logic [7:0] note_led(input note_t n);
        logic [7:0] v;
        v = '0;
        if (n != NOTE_NONE)
            v = 8'h80 >> (4'(n) - 4'd1);
        return v;
    endfunction

endpackage

// File: rtl/tone_decoder_if.sv
// Tone loopback input and decoded-note result bundle.
interface tone_decoder_if;
    import tone_decoder_pkg::*;

    logic       TONE_IN;
    note_t      note;
    logic       valid;
    logic       changed;
    logic [7:0] Led;

    modport master (
        input  TONE_IN,
        output note,
        output valid,
        output changed,
        output Led
    );

    modport slave (
        output TONE_IN,
        input  note,
        input  valid,
        input  changed,
        input  Led
    );

endinterface

// File: rtl/tone_decoder_meter.sv
// Period meter: synchronizer, edge detect, saturating period counter.
// TONE_DECODER_MAJORITY_EN adds a 3-sample glitch filter (+2 CLK).
module tone_period_meter #(
    parameter int PW = 20
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          tone_in,
    output logic          rise,
    output logic [PW-1:0] period
);

    logic [1:0]    sync_q;
    logic          sample;
    logic          prev_q;
    logic [PW-1:0] cnt_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            sync_q <= '0;
        else
            sync_q <= {sync_q[0], tone_in};
    end

`ifdef TONE_DECODER_MAJORITY_EN
    logic [1:0] hist_q;
    logic       filt_q;
    logic       maj;

    assign maj = (sync_q[1] & hist_q[0]) |
                 (sync_q[1] & hist_q[1]) |
                 (hist_q[0] & hist_q[1]);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            hist_q <= '0;
            filt_q <= 1'b0;
        end else begin
            hist_q <= {hist_q[0], sync_q[1]};
            filt_q <= maj;
        end
    end

    assign sample = filt_q;
`else
    assign sample = sync_q[1];
`endif

    assign rise = sample & ~prev_q;

    // Cleared to 1 so the value seen on the next rise is the full period
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            prev_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            prev_q <= sample;
            if (rise)
                cnt_q <= PW'(1);
            else if (cnt_q != '1)
                cnt_q <= cnt_q + PW'(1);
        end
    end

    assign period = cnt_q;

endmodule

// File: rtl/tone_decoder.sv
// Classifies the measured TONE_IN period as a scale note C4..C5 and
// locks it after LOCK_CNT consecutive matching periods.
module tone_decoder
    import tone_decoder_pkg::*;
#(
    parameter int PW         = 20,
    parameter int TOL_SHIFT  = 6,
    parameter int LOCK_CNT   = 3,
    parameter int TIMEOUT    = 1000000,
    // Nominal periods are divided by 2^NOTE_SHIFT (0 = real 100 MHz values)
    parameter int NOTE_SHIFT = 0
) (
    input  logic           CLK,
    input  logic           RESET,
    tone_decoder_if.master bus
);

    localparam int MW = $clog2(LOCK_CNT + 1);

    logic          rise;
    logic [PW-1:0] period;
    logic          timeout;
    note_t         cls;

    state_t        state_q, state_d;
    note_t         cand_q, cand_d;
    logic [MW-1:0] mcnt_q, mcnt_d;
    note_t         note_q, note_d;
    logic          valid_q, valid_d;
    logic          changed_q;
    logic [7:0]    led_q;

    tone_period_meter #(
        .PW(PW)
    ) u_meter (
        .CLK    (CLK),
        .RESET  (RESET),
        .tone_in(bus.TONE_IN),
        .rise   (rise),
        .period (period)
    );

    assign cls = classify(32'(period), NOTE_SHIFT, TOL_SHIFT);

    // Silence needs no timeout; gating it lets the first edge start a measurement
    assign timeout = (state_q != ST_SILENT) && (period >= PW'(TIMEOUT));

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        mcnt_d  = mcnt_q;
        note_d  = note_q;
        valid_d = valid_q;
        if (timeout) begin
            state_d = ST_SILENT;
            cand_d  = NOTE_NONE;
            mcnt_d  = '0;
            note_d  = NOTE_NONE;
            valid_d = 1'b0;
        end else if (rise) begin
            unique case (state_q)
                ST_SILENT: begin
                    state_d = ST_ACQUIRE;
                    cand_d  = NOTE_NONE;
                    mcnt_d  = '0;
                end
                ST_ACQUIRE: begin
                    if (cls == NOTE_NONE) begin
                        cand_d = NOTE_NONE;
                        mcnt_d = '0;
                    end else if (cls == cand_q) begin
                        mcnt_d = mcnt_q + MW'(1);
                    end else begin
                        cand_d = cls;
                        mcnt_d = MW'(1);
                    end
                end
                ST_LOCKED: begin
                    if (cls != note_q) begin
                        state_d = ST_ACQUIRE;
                        cand_d  = cls;
                        mcnt_d  = (cls == NOTE_NONE) ? '0 : MW'(1);
                    end
                end
                default: begin
                    state_d = ST_SILENT;
                end
            endcase
            if (state_d == ST_ACQUIRE && cand_d != NOTE_NONE &&
                mcnt_d >= MW'(LOCK_CNT)) begin
                state_d = ST_LOCKED;
                note_d  = cand_d;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= ST_SILENT;
            cand_q    <= NOTE_NONE;
            mcnt_q    <= '0;
            note_q    <= NOTE_NONE;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
            led_q     <= '0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            mcnt_q    <= mcnt_d;
            note_q    <= note_d;
            valid_q   <= valid_d;
            changed_q <= (note_d != note_q);
            led_q     <= note_led(note_d);
        end
    end

    assign bus.note    = note_q;
    assign bus.valid   = valid_q;
    assign bus.changed = changed_q;
    assign bus.Led     = led_q;

endmodule

// File: tb/tb_tone_decoder.sv
// Directed bench for tone_decoder with nominal periods scaled by 2^-8.
// Optional build: TONE_DECODER_MAJORITY_EN.
module tb_tone_decoder;

    // Nominal periods >> 8
    localparam int PA   = 887;
    localparam int PC5  = 746;
    localparam int PE   = 1185;
    localparam int PC4  = 1493;
    localparam int PGAP = 937;
    localparam int TO   = 4000;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   chg   = 0;

    tone_decoder_if bus ();

    always #5 CLK = ~CLK;

    tone_decoder #(
        .PW        (16),
        .TOL_SHIFT (6),
        .LOCK_CNT  (3),
        .TIMEOUT   (TO),
        .NOTE_SHIFT(8)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus)
    );

    always @(negedge CLK)
        if (bus.changed === 1'b1)
            chg++;

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic edges(input int per, input int n);
        for (int i = 0; i < n; i++) begin
            bus.TONE_IN = 1'b1;
            cyc(per / 2);
            bus.TONE_IN = 1'b0;
            cyc(per - per / 2);
        end
    endtask

    task automatic test_reset;
        RESET       = 1'b1;
        bus.TONE_IN = 1'b0;
        cyc(2);
        for (int i = 0; i < 4; i++) begin
            edges(50, 1);
            n_cmp++;
            if (bus.note !== 4'd0 || bus.valid !== 1'b0 || bus.Led !== 8'd0) begin
                n_bad++;
                $display("FAIL reset_hold: note=%0d valid=%0b Led=%b want 0/0/0",
                         bus.note, bus.valid, bus.Led);
            end
        end
        RESET = 1'b0;
        cyc(3);
        edges(PA, 3);
        n_cmp++;
        if (bus.valid !== 1'b0 || bus.note !== 4'd0) begin
            n_bad++;
            $display("FAIL no_early_lock: valid=%0b note=%0d want 0/0",
                     bus.valid, bus.note);
        end
    endtask

    task automatic test_lock_a;
        int c0;
        c0 = chg;
        bus.TONE_IN = 1'b1;
        cyc(2);
        n_cmp++;
        if (bus.valid !== 1'b0) begin
            n_bad++;
            $display("FAIL lock_a_early: valid=%0b want 0", bus.valid);
        end
        cyc(4);
        n_cmp++;
        if (bus.note !== 4'd6 || bus.valid !== 1'b1) begin
            n_bad++;
            $display("FAIL lock_a: note=%0d valid=%0b want 6/1",
                     bus.note, bus.valid);
        end
        n_cmp++;
        if (bus.Led !== 8'b0000_0100) begin
            n_bad++;
            $display("FAIL lock_a_led: Led=%b want 00000100", bus.Led);
        end
        cyc(PA / 2 - 6);
        bus.TONE_IN = 1'b0;
        cyc(PA - PA / 2);
        n_cmp++;
        if (chg - c0 !== 1) begin
            n_bad++;
            $display("FAIL lock_a_changed: pulses=%0d want 1", chg - c0);
        end
    endtask

    task automatic test_switch_c5;
        int c0;
        c0 = chg;
        edges(PC5, 3);
        n_cmp++;
        if (bus.note !== 4'd6 || bus.valid !== 1'b1) begin
            n_bad++;
            $display("FAIL c5_hold: note=%0d valid=%0b want 6/1",
                     bus.note, bus.valid);
        end
        edges(PC5, 1);
        n_cmp++;
        if (bus.note !== 4'd8 || bus.Led !== 8'b0000_0001) begin
            n_bad++;
            $display("FAIL c5_lock: note=%0d Led=%b want 8/00000001",
                     bus.note, bus.Led);
        end
        n_cmp++;
        if (chg - c0 !== 1) begin
            n_bad++;
            $display("FAIL c5_changed: pulses=%0d want 1", chg - c0);
        end
    endtask

    task automatic test_timeout;
        int c0;
        edges(PE, 4);
        n_cmp++;
        if (bus.note !== 4'd3 || bus.Led !== 8'b0010_0000) begin
            n_bad++;
            $display("FAIL e_lock: note=%0d Led=%b want 3/00100000",
                     bus.note, bus.Led);
        end
        c0 = chg;
        cyc(TO - 10 - PE);
        n_cmp++;
        if (bus.valid !== 1'b1 || bus.note !== 4'd3) begin
            n_bad++;
            $display("FAIL pre_timeout: valid=%0b note=%0d want 1/3",
                     bus.valid, bus.note);
        end
        cyc(20);
        n_cmp++;
        if (bus.valid !== 1'b0 || bus.note !== 4'd0 || bus.Led !== 8'd0) begin
            n_bad++;
            $display("FAIL timeout: valid=%0b note=%0d Led=%b want 0/0/0",
                     bus.valid, bus.note, bus.Led);
        end
        n_cmp++;
        if (chg - c0 !== 1) begin
            n_bad++;
            $display("FAIL timeout_changed: pulses=%0d want 1", chg - c0);
        end
    endtask

    task automatic test_gap;
        int c0;
        c0 = chg;
        edges(PGAP, 6);
        n_cmp++;
        if (bus.valid !== 1'b0 || bus.note !== 4'd0) begin
            n_bad++;
            $display("FAIL gap: valid=%0b note=%0d want 0/0",
                     bus.valid, bus.note);
        end
        cyc(TO + 50);
        n_cmp++;
        if (chg - c0 !== 0) begin
            n_bad++;
            $display("FAIL gap_changed: pulses=%0d want 0", chg - c0);
        end
    endtask

    task automatic test_glitch;
        int c0;
        edges(PC4, 4);
        n_cmp++;
        if (bus.note !== 4'd1 || bus.Led !== 8'b1000_0000) begin
            n_bad++;
            $display("FAIL c4_lock: note=%0d Led=%b want 1/10000000",
                     bus.note, bus.Led);
        end
        c0 = chg;
        bus.TONE_IN = 1'b1;
        cyc(PC4 / 2);
        bus.TONE_IN = 1'b0;
        cyc(1300 - PC4 / 2);
        bus.TONE_IN = 1'b1;
        cyc(1);
        bus.TONE_IN = 1'b0;
        cyc(PC4 - 1301);
        edges(PC4, 3);
        n_cmp++;
        if (bus.note !== 4'd1 || bus.valid !== 1'b1) begin
            n_bad++;
            $display("FAIL glitch_hold: note=%0d valid=%0b want 1/1",
                     bus.note, bus.valid);
        end
        n_cmp++;
        if (chg - c0 !== 0) begin
            n_bad++;
            $display("FAIL glitch_changed: pulses=%0d want 0", chg - c0);
        end
    endtask

    task automatic test_async_reset;
        bus.TONE_IN = 1'b1;
        cyc(100);
        #3;
        RESET = 1'b1;
        #1;
        n_cmp++;
        if (bus.note !== 4'd0 || bus.valid !== 1'b0 || bus.Led !== 8'd0) begin
            n_bad++;
            $display("FAIL async_reset: note=%0d valid=%0b Led=%b want 0/0/0",
                     bus.note, bus.valid, bus.Led);
        end
        bus.TONE_IN = 1'b0;
        cyc(3);
        RESET = 1'b0;
        cyc(2);
        edges(PC4, 3);
        n_cmp++;
        if (bus.valid !== 1'b0) begin
            n_bad++;
            $display("FAIL relock_early: valid=%0b want 0", bus.valid);
        end
        edges(PC4, 1);
        n_cmp++;
        if (bus.note !== 4'd1 || bus.valid !== 1'b1) begin
            n_bad++;
            $display("FAIL relock: note=%0d valid=%0b want 1/1",
                     bus.note, bus.valid);
        end
    endtask

    initial begin
        bus.TONE_IN = 1'b0;
        test_reset();
        test_lock_a();
        test_switch_c5();
        test_timeout();
        test_gap();
        test_glitch();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
